// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-operand and result bundle for alu_cmd_sequencer.
// master = command issuer / ALU side, slave = the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int unsigned W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_ra;
  logic [1:0]   cmd_rb;
  logic [1:0]   cmd_rd;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_oper;
  logic [W-1:0] alu_out;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [1:0]   res_rd;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, res_ready, alu_out,
    input  cmd_ready, res_valid, res_data, res_rd, alu_a, alu_b, alu_oper
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, res_ready, alu_out,
    output cmd_ready, res_valid, res_data, res_rd, alu_a, alu_b, alu_oper
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Register-to-register command sequencer driving a combinational ALU:
// reads operands from a 4-entry register file, waits ALU_WAIT cycles, writes back and returns the result.
module alu_cmd_sequencer #(
  parameter int unsigned W        = 4,
  parameter int unsigned ALU_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_sequencer_if.slave bus,
  input  logic               ld_en,
  input  logic [1:0]         ld_addr,
  input  logic [W-1:0]       ld_data,
  output logic               busy
);

  localparam int unsigned CW   = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  localparam int unsigned NREG = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [W-1:0]  alu_a_q,     alu_a_d;
  logic [W-1:0]  alu_b_q,     alu_b_d;
  logic [2:0]    alu_oper_q,  alu_oper_d;
  logic [W-1:0]  res_data_q,  res_data_d;
  logic [1:0]    res_rd_q,    res_rd_d;
  logic          res_valid_q, res_valid_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q,      busy_d;
  logic [W-1:0]  rf_q [NREG];
  logic [W-1:0]  rf_d [NREG];
  logic          wb;

  // Next-state, datapath capture and register-file update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_oper_d = alu_oper_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    rf_d       = rf_q;
    wb         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d    = rf_q[bus.cmd_ra];
          alu_b_d    = rf_q[bus.cmd_rb];
          alu_oper_d = bus.cmd_op;
          res_rd_d   = bus.cmd_rd;
          cnt_d      = CW'(ALU_WAIT - 1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          res_data_d = bus.alu_out;
          wb         = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Writeback is applied last so it overrides a same-address direct load
    if (ld_en) rf_d[ld_addr] = ld_data;
    if (wb)    rf_d[res_rd_q] = bus.alu_out;

    res_valid_d = (state_d == S_RESP);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_oper_q  <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rf_q        <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_oper_q  <= alu_oper_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rf_q        <= rf_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_oper  = alu_oper_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: two sequencers (ALU_WAIT=1 and 3) share stimulus, selected by sel,
// and are compared against a register-file model plus an ALU stub.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sel;
  logic         cmd_valid;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_ra, cmd_rb, cmd_rd;
  logic         res_ready;
  logic         ld_en;
  logic [1:0]   ld_addr;
  logic [W-1:0] ld_data;
  logic         busy0, busy1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mdl [2][4];
  int           wait_of [2] = '{1, 3};
  logic [2:0]   ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

  alu_cmd_sequencer_if #(.W(W)) if0 ();
  alu_cmd_sequencer_if #(.W(W)) if1 ();

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return W'(a + b);
      3'b001:  return W'(a - b);
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b111:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign if0.alu_out   = alu_f(if0.alu_a, if0.alu_b, if0.alu_oper);
  assign if1.alu_out   = alu_f(if1.alu_a, if1.alu_b, if1.alu_oper);
  assign if0.cmd_valid = cmd_valid & ~sel;
  assign if1.cmd_valid = cmd_valid & sel;
  assign if0.cmd_op    = cmd_op;
  assign if1.cmd_op    = cmd_op;
  assign if0.cmd_ra    = cmd_ra;
  assign if1.cmd_ra    = cmd_ra;
  assign if0.cmd_rb    = cmd_rb;
  assign if1.cmd_rb    = cmd_rb;
  assign if0.cmd_rd    = cmd_rd;
  assign if1.cmd_rd    = cmd_rd;
  assign if0.res_ready = res_ready;
  assign if1.res_ready = res_ready;

  alu_cmd_sequencer #(.W(W), .ALU_WAIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0),
    .ld_en(ld_en & ~sel), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy0)
  );

  alu_cmd_sequencer #(.W(W), .ALU_WAIT(3)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1),
    .ld_en(ld_en & sel), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy1)
  );

  logic         m_cmd_ready, m_res_valid, m_busy;
  logic [W-1:0] m_res_data, m_alu_a, m_alu_b;
  logic [1:0]   m_res_rd;
  logic [2:0]   m_alu_oper;
  assign m_cmd_ready = sel ? if1.cmd_ready : if0.cmd_ready;
  assign m_res_valid = sel ? if1.res_valid : if0.res_valid;
  assign m_res_data  = sel ? if1.res_data  : if0.res_data;
  assign m_res_rd    = sel ? if1.res_rd    : if0.res_rd;
  assign m_alu_a     = sel ? if1.alu_a     : if0.alu_a;
  assign m_alu_b     = sel ? if1.alu_b     : if0.alu_b;
  assign m_alu_oper  = sel ? if1.alu_oper  : if0.alu_oper;
  assign m_busy      = sel ? busy1         : busy0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 4; r++) mdl[s][r] = '0;
  endtask

  task automatic ld_reg(input logic [1:0] a, input logic [W-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    mdl[sel ? 1 : 0][a] = d;
  endtask

  // ld_when: 0 none, 1 load in the accept cycle, 2 load on the writeback edge
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input int hold, input int ld_when,
                         input logic [1:0] la, input logic [W-1:0] lv, output logic [W-1:0] got);
    logic [W-1:0] ea, eb, ev;
    int s, k;
    s  = sel ? 1 : 0;
    ea = mdl[s][ra];
    eb = mdl[s][rb];
    ev = alu_f(ea, eb, op);
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    cmd_valid = 1'b1;
    res_ready = (hold == 0);
    k = 0;
    while (!m_cmd_ready && k < 20) begin tick(); k++; end
    chk("accept_ready", 32'(m_cmd_ready), 32'd1);
    if (ld_when == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    tick();
    cmd_valid = 1'b0;
    ld_en     = 1'b0;
    if (ld_when == 1) mdl[s][la] = lv;
    k = 0;
    while (!m_res_valid && k < 20) begin
      chk("wait_alu_a", 32'(m_alu_a), 32'(ea));
      chk("wait_alu_b", 32'(m_alu_b), 32'(eb));
      chk("wait_alu_oper", 32'(m_alu_oper), 32'(op));
      chk("wait_busy", 32'(m_busy), 32'd1);
      chk("wait_cmd_ready", 32'(m_cmd_ready), 32'd0);
      if (ld_when == 2 && k == wait_of[s] - 1) begin
        ld_en = 1'b1; ld_addr = la; ld_data = lv;
      end
      tick();
      ld_en = 1'b0;
      k++;
    end
    if (ld_when == 2) mdl[s][la] = lv;
    mdl[s][rd] = ev;
    chk("latency", 32'(k), 32'(wait_of[s]));
    chk("res_data", 32'(m_res_data), 32'(ev));
    chk("res_rd", 32'(m_res_rd), 32'(rd));
    got = m_res_data;
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_op = ~op; cmd_ra = ~ra; cmd_rb = ~rb; cmd_rd = ~rd;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_valid", 32'(m_res_valid), 32'd1);
        chk("hold_data", 32'(m_res_data), 32'(ev));
        chk("hold_rd", 32'(m_res_rd), 32'(rd));
        chk("hold_cmd_ready", 32'(m_cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
    end
    tick();
    chk("res_drop", 32'(m_res_valid), 32'd0);
    chk("idle_ready", 32'(m_cmd_ready), 32'd1);
    chk("idle_busy", 32'(m_busy), 32'd0);
    chk("idle_alu_oper", 32'(m_alu_oper), 32'(op));
    chk("idle_alu_a", 32'(m_alu_a), 32'(ea));
  endtask

  // Non-destructive read of a register: r | r written back to r
  task automatic peek(input logic [1:0] r, output logic [W-1:0] v);
    run_cmd(3'b011, r, r, r, 0, 0, 2'd0, '0, v);
  endtask

  initial begin
    logic [W-1:0] v;
    sel = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
    res_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", 32'(if0.cmd_ready), 32'd1);
    chk("rst_valid0", 32'(if0.res_valid), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_alu_a0", 32'(if0.alu_a), 32'd0);
    chk("rst_oper1", 32'(if1.alu_oper), 32'd0);
    chk("rst_res_data0", 32'(if0.res_data), 32'd0);
    chk("rst_res_rd1", 32'(if1.res_rd), 32'd0);

    // Basic add with writeback
    ld_reg(2'd0, 4'd3);
    ld_reg(2'd1, 4'd1);
    run_cmd(3'b000, 2'd0, 2'd1, 2'd2, 0, 0, 2'd0, '0, v);
    chk("t1_sum", 32'(v), 32'd4);
    peek(2'd2, v);
    chk("t1_rf2", 32'(v), 32'd4);

    // Wraparound add and subtract
    ld_reg(2'd0, 4'hF);
    run_cmd(3'b000, 2'd0, 2'd1, 2'd3, 0, 0, 2'd0, '0, v);
    chk("t2_wrap", 32'(v), 32'd0);
    run_cmd(3'b001, 2'd1, 2'd0, 2'd3, 0, 0, 2'd0, '0, v);
    chk("t2_sub", 32'(v), 32'd2);
    peek(2'd3, v);
    chk("t2_rf3", 32'(v), 32'd2);

    // Result back-pressure with an intruding command
    run_cmd(3'b111, 2'd2, 2'd3, 2'd1, 5, 0, 2'd0, '0, v);
    chk("t3_xor", 32'(v), 32'd6);

    // ALU_WAIT=3 and loads on the writeback edge
    sel = 1'b1;
    #1;
    ld_reg(2'd0, 4'd5);
    ld_reg(2'd1, 4'd6);
    run_cmd(3'b000, 2'd0, 2'd1, 2'd2, 0, 2, 2'd2, 4'hF, v);
    peek(2'd2, v);
    chk("t4_wb_wins", 32'(v), 32'hB);
    run_cmd(3'b010, 2'd0, 2'd1, 2'd3, 0, 2, 2'd0, 4'h9, v);
    peek(2'd3, v);
    chk("t4_both_rd", 32'(v), 32'd4);
    peek(2'd0, v);
    chk("t4_both_ld", 32'(v), 32'd9);

    // Load in the accept cycle: command sees the old operand
    sel = 1'b0;
    #1;
    run_cmd(3'b000, 2'd1, 2'd1, 2'd0, 0, 1, 2'd1, 4'h9, v);
    chk("t5_old_ra", 32'(v), 32'hC);
    peek(2'd1, v);
    chk("t5_new_ra", 32'(v), 32'd9);

    // Randomized commands, loads and back-pressure
    for (int it = 0; it < 40; it++) begin
      sel = 1'($urandom_range(0, 1));
      #1;
      if ($urandom_range(0, 2) == 0) ld_reg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      run_cmd(ops[$urandom_range(0, 4)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), v);
    end
    for (int r = 0; r < 4; r++) peek(2'(r), v);

    // Reset while a command is in WAIT
    sel = 1'b1;
    #1;
    ld_reg(2'd0, 4'd7);
    ld_reg(2'd1, 4'd1);
    cmd_op = 3'b000; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6_in_wait", 32'(busy1), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_alu_a", 32'(if1.alu_a), 32'd0);
    chk("t6_alu_b", 32'(if1.alu_b), 32'd0);
    chk("t6_alu_oper", 32'(if1.alu_oper), 32'd0);
    chk("t6_res_data", 32'(if1.res_data), 32'd0);
    chk("t6_res_rd", 32'(if1.res_rd), 32'd0);
    chk("t6_res_valid", 32'(if1.res_valid), 32'd0);
    chk("t6_busy", 32'(busy1), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    clear_model();
    tick();
    chk("t6_ready_after", 32'(if1.cmd_ready), 32'd1);
    repeat (4) tick();
    chk("t6_no_resp", 32'(if1.res_valid), 32'd0);
    peek(2'd2, v);
    chk("t6_no_wb", 32'(v), 32'd0);
    peek(2'd0, v);
    chk("t6_rf_clr", 32'(v), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
